// File: rtl/prga_if.sv
// prga_if: start handshake plus the S, ciphertext and plaintext memory ports of the PRGA stage.
interface prga_if;
  logic       en;
  logic       rdy;
  logic       pt_ok;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  // Environment side: issues start requests and returns memory read data.
  modport master (
    output en, s_rddata, ct_rddata,
    input  rdy, pt_ok, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  // PRGA side: drives memory addresses/writes and reports status.
  modport slave (
    input  en, s_rddata, ct_rddata,
    output rdy, pt_ok, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/prga.sv
// prga: ARC4 keystream generation and decryption of a length-prefixed message.
// All outputs are registered; each output flop is loaded on the edge entering the
// state in which the spec wants it visible.
module prga #(
  parameter bit ABORT = 1'b1
) (
  input  logic    clk,
  input  logic    rst_n,
  prga_if.slave   bus
);
  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] PRINT_LO = 8'h20;
  localparam logic [DW-1:0] PRINT_HI = 8'h7E;

  typedef enum logic [3:0] {
    IDLE, LEN_A, LEN_D, LEN_W, SI_A, SI_D, SJ_A, SJ_D,
    WR_I, WR_J, PAD_A, PAD_D, WR_PT
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
  logic [DW-1:0] si_q, si_d, sj_q, sj_d, pad_q, pad_d, ct_byte_q, ct_byte_d;
  logic          rdy_q, rdy_d, pt_ok_q, pt_ok_d;
  logic [DW-1:0] s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
  logic          s_wren_q, s_wren_d;
  logic [DW-1:0] ct_addr_q, ct_addr_d, pt_addr_q, pt_addr_d, pt_wrdata_q, pt_wrdata_d;
  logic          pt_wren_q, pt_wren_d;
  logic [DW-1:0] pt_byte_c;
  logic          bad_c;

  // Plaintext byte being committed in WR_PT and its printability.
  assign pt_byte_c = pad_q ^ ct_byte_q;
  assign bad_c     = (pt_byte_c < PRINT_LO) || (pt_byte_c > PRINT_HI);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    si_d        = si_q;
    sj_d        = sj_q;
    pad_d       = pad_q;
    ct_byte_d   = ct_byte_q;
    pt_ok_d     = pt_ok_q;
    s_addr_d    = s_addr_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    pt_wren_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          i_d       = '0;
          j_d       = '0;
          k_d       = '0;
          pt_ok_d   = 1'b1;
          ct_addr_d = '0;
          state_d   = LEN_A;
        end
      end
      LEN_A: state_d = LEN_D;
      LEN_D: begin
        len_d       = bus.ct_rddata;
        pt_addr_d   = '0;
        pt_wrdata_d = bus.ct_rddata;
        pt_wren_d   = 1'b1;
        state_d     = LEN_W;
      end
      LEN_W: begin
        if (len_q == '0) begin
          state_d = IDLE;
        end else begin
          k_d      = DW'(1);
          i_d      = i_q + DW'(1);
          s_addr_d = i_q + DW'(1);
          state_d  = SI_A;
        end
      end
      SI_A: state_d = SI_D;
      SI_D: begin
        si_d     = bus.s_rddata;
        j_d      = j_q + bus.s_rddata;
        s_addr_d = j_q + bus.s_rddata;
        state_d  = SJ_A;
      end
      SJ_A: state_d = SJ_D;
      SJ_D: begin
        sj_d       = bus.s_rddata;
        s_addr_d   = i_q;
        s_wrdata_d = bus.s_rddata;
        s_wren_d   = 1'b1;
        state_d    = WR_I;
      end
      WR_I: begin
        s_addr_d   = j_q;
        s_wrdata_d = si_q;
        s_wren_d   = 1'b1;
        state_d    = WR_J;
      end
      WR_J: begin
        s_addr_d  = si_q + sj_q;
        ct_addr_d = k_q;
        state_d   = PAD_A;
      end
      PAD_A: state_d = PAD_D;
      PAD_D: begin
        pad_d       = bus.s_rddata;
        ct_byte_d   = bus.ct_rddata;
        pt_addr_d   = k_q;
        pt_wrdata_d = bus.s_rddata ^ bus.ct_rddata;
        pt_wren_d   = 1'b1;
        state_d     = WR_PT;
      end
      WR_PT: begin
        if (bad_c) pt_ok_d = 1'b0;
        if ((k_q == len_q) || (ABORT && bad_c)) begin
          state_d = IDLE;
        end else begin
          k_d      = k_q + DW'(1);
          i_d      = i_q + DW'(1);
          s_addr_d = i_q + DW'(1);
          state_d  = SI_A;
        end
      end
      default: state_d = IDLE;
    endcase

    rdy_d = (state_d == IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      len_q       <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      pad_q       <= '0;
      ct_byte_q   <= '0;
      rdy_q       <= 1'b1;
      pt_ok_q     <= 1'b0;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      pad_q       <= pad_d;
      ct_byte_q   <= ct_byte_d;
      rdy_q       <= rdy_d;
      pt_ok_q     <= pt_ok_d;
      s_addr_q    <= s_addr_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
      pt_wren_q   <= pt_wren_d;
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.pt_ok     = pt_ok_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_wrdata  = s_wrdata_q;
  assign bus.s_wren    = s_wren_q;
  assign bus.ct_addr   = ct_addr_q;
  assign bus.pt_addr   = pt_addr_q;
  assign bus.pt_wrdata = pt_wrdata_q;
  assign bus.pt_wren   = pt_wren_q;
endmodule
